onchip_memory_arbiter: RTL and testbench
========================================

ONCHIP_MEMORY_ARBITER -- requirements
Module: onchip_memory_arbiter

Interface
REQ-001 SHALL have parameter ARB_MODE, default 0, meaning 0 = round-robin, 1 = fixed priority m0 with starvation guard.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive contested m0 wins before m1 is forced a grant (ARB_MODE=1 only), range 1..15.
REQ-003 SHALL use one clock and asynchronous active-low reset: clk (input, 1 bit, rising-edge clock) and reset_n (input, 1 bit, asynchronous active-low reset).
REQ-004 SHALL have mN_address, input, 10 bits, word address from requester N (N = 0, 1; one port per N).
REQ-005 SHALL have mN_read, input, 1 bit, read request.
REQ-006 SHALL have mN_write, input, 1 bit, write request.
REQ-007 SHALL have mN_byteenable, input, 4 bits, byte lanes.
REQ-008 SHALL have mN_writedata, input, 32 bits, write data.
REQ-009 SHALL have mN_waitrequest, output, 1 bit, request not accepted this cycle.
REQ-010 SHALL have mN_readdata, output, 32 bits, read data, valid only with mN_readdatavalid.
REQ-011 SHALL have mN_readdatavalid, output, 1 bit, read data strobe.
REQ-012 SHALL have mem_address (output, 10 bits), mem_byteenable (output, 4 bits), mem_writedata (output, 32 bits), mem_chipselect (output, 1 bit), mem_write (output, 1 bit), mem_clken (output, 1 bit) and mem_readdata (input, 32 bits), all to the single-port 1024x32 RAM.

Function
REQ-013 SHALL treat requester N as active when mN_read | mN_write; mN_read and mN_write both high is illegal and SHALL be treated as a write.
REQ-014 SHALL grant at most one requester per cycle, combinationally from the active signals and registered state, with zero-cycle acceptance when uncontested.
REQ-015 SHALL drive mN_waitrequest = active_N & ~grant_N, and drive it low when requester N is idle.
REQ-016 SHALL drive mem_chipselect = any grant, mem_write = granted write, and address, byteenable and writedata muxed from the granted requester; mem_clken SHALL be tied to 1.
REQ-017 ARB_MODE=0 SHALL give a contested cycle to the requester not in last_grant; last_grant SHALL update only on a grant.
REQ-018 ARB_MODE=1 SHALL give a contested cycle to m0, and SHALL increment starve_cnt on each such cycle; when starve_cnt = STARVE_LIMIT, m1 SHALL win and starve_cnt SHALL clear. starve_cnt SHALL clear whenever m1 is granted or no contention occurs.
REQ-019 SHALL have fixed read latency 1: for a granted read in cycle T, mN_readdatavalid of the owner SHALL be high in T+1 only, with mN_readdata = mem_readdata.
REQ-020 SHALL track the read pipeline with registers rd_vld_q and rd_own_q; back-to-back reads from alternating owners SHALL each return in order with no bubble.
REQ-021 Writes SHALL complete in the grant cycle and SHALL produce no readdatavalid.
REQ-022 A write in cycle T followed by a read of the same address in T+1 SHALL return the new data; the arbiter SHALL never issue two accesses in one cycle.
REQ-023 mN_readdata SHALL be mem_readdata to both ports unconditionally; the requester SHALL qualify it with readdatavalid.

Reset
REQ-024 On reset_n low, SHALL asynchronously set last_grant = 1 (m0 wins first contest), starve_cnt = 0, rd_vld_q = 0 and rd_own_q = 0.
REQ-025 During reset, all mN_readdatavalid SHALL be 0; mem_chipselect and mem_write SHALL be 0 regardless of inputs; mN_waitrequest SHALL be 1 for active requesters.
REQ-026 A read granted in the cycle before reset assertion SHALL be dropped, with no readdatavalid after reset release.

Structure
REQ-027 Package onchip_arb_pkg SHALL hold ADDR_W=10, DATA_W=32, BE_W=4 and the ARB_MODE encodings.
REQ-028 Grant selection (REQ-017, REQ-018, including last_grant and starve_cnt) SHALL live in sub-module onchip_arb_grant; the top SHALL hold the muxing and the read pipeline.

Verification
REQ-029 Reset release with both idle: all waitrequest=0, readdatavalid=0, mem_chipselect=0.
REQ-030 ARB_MODE=0, m0 and m1 read addr 0x010/0x020 continuously: grants alternate m0,m1,m0...; each readdatavalid is high one cycle after its grant with the correct word.
REQ-031 m1 writes 0xDEADBEEF with be=4'b0011 to 0x3FF, then m0 reads 0x3FF next cycle: readdata[15:0]=0xBEEF and upper bytes unchanged.
REQ-032 ARB_MODE=1, STARVE_LIMIT=4, both continuously active: m0 granted 4 cycles, m1 once, repeating; m1_waitrequest is low every 5th cycle.
REQ-033 m0 read granted, then reset_n pulsed low mid-cycle before T+1: no m0_readdatavalid; first post-reset contest is won by m0.

Source files
------------

// File: rtl/onchip_arb_pkg.sv
// Shared widths, arbitration mode encodings and requester ids for the
// two-port on-chip memory arbiter.
package onchip_arb_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    localparam int ARB_MODE_RR    = 0;
    localparam int ARB_MODE_FIXED = 1;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_e;

endpackage

// File: rtl/onchip_arb_grant.sv
// Grant selection between two requesters: round-robin, or fixed priority
// to m0 with a starvation guard that periodically forces a grant to m1.
module onchip_arb_grant
    import onchip_arb_pkg::*;
#(
    parameter int ARB_MODE     = ARB_MODE_RR,
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic active0_i,
    input  logic active1_i,
    output logic grant0_o,
    output logic grant1_o
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    owner_e     last_grant_q, last_grant_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       contested;
    logic       g0, g1;

    assign contested = active0_i & active1_i;

    always_comb begin
        g0           = 1'b0;
        g1           = 1'b0;
        last_grant_d = last_grant_q;
        starve_cnt_d = '0;
        // Grants are held off while reset is asserted so nothing reaches the RAM.
        if (reset_n) begin
            if (contested) begin
                if (ARB_MODE == ARB_MODE_FIXED) begin
                    g1 = (starve_cnt_q == LIMIT);
                    g0 = ~g1;
                end else begin
                    g0 = (last_grant_q == OWN_M1);
                    g1 = ~g0;
                end
            end else begin
                g0 = active0_i;
                g1 = active1_i;
            end
            if (g0) last_grant_d = OWN_M0;
            if (g1) last_grant_d = OWN_M1;
            if ((ARB_MODE == ARB_MODE_FIXED) && contested && g0) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= OWN_M1;
            starve_cnt_q <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign grant0_o = g0;
    assign grant1_o = g1;

endmodule

// File: rtl/onchip_memory_arbiter.sv
// Two-requester arbiter in front of a single-port 1024x32 RAM with
// one-cycle read latency; holds the request mux and the read-return pipeline.
module onchip_memory_arbiter
    import onchip_arb_pkg::*;
#(
    parameter int ARB_MODE     = ARB_MODE_RR,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    logic   active0, active1;
    logic   grant0, grant1;
    logic   rd_vld_q, rd_vld_d;
    owner_e rd_own_q, rd_own_d;

    assign active0 = m0_read | m0_write;
    assign active1 = m1_read | m1_write;

    onchip_arb_grant #(
        .ARB_MODE     (ARB_MODE),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .clk       (clk),
        .reset_n   (reset_n),
        .active0_i (active0),
        .active1_i (active1),
        .grant0_o  (grant0),
        .grant1_o  (grant1)
    );

    assign m0_waitrequest = active0 & ~grant0;
    assign m1_waitrequest = active1 & ~grant1;

    assign mem_chipselect = grant0 | grant1;
    assign mem_write      = (grant0 & m0_write) | (grant1 & m1_write);
    assign mem_address    = grant1 ? m1_address    : m0_address;
    assign mem_byteenable = grant1 ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = grant1 ? m1_writedata  : m0_writedata;
    assign mem_clken      = 1'b1;

    // Read+write together counts as a write, so it never enters the read pipe.
    always_comb begin
        rd_vld_d = (grant0 & ~m0_write) | (grant1 & ~m1_write);
        rd_own_d = grant1 ? OWN_M1 : OWN_M0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld_q <= 1'b0;
            rd_own_q <= OWN_M0;
        end else begin
            rd_vld_q <= rd_vld_d;
            rd_own_q <= rd_own_d;
        end
    end

    assign m0_readdatavalid = rd_vld_q & (rd_own_q == OWN_M0);
    assign m1_readdatavalid = rd_vld_q & (rd_own_q == OWN_M1);
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with identical stimulus,
// each backed by its own RAM, and checks both against a behavioural model.
module tb_onchip_memory_arbiter;

    localparam int LIMIT = 4;

    logic clk;
    logic reset_n;

    logic [9:0]  m0_address, m1_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic [31:0] m0_writedata, m1_writedata;

    logic        wr0 [2];
    logic        wr1 [2];
    logic        rdv0 [2];
    logic        rdv1 [2];
    logic [31:0] rd0 [2];
    logic [31:0] rd1 [2];
    logic [9:0]  mem_addr [2];
    logic [3:0]  mem_be [2];
    logic [31:0] mem_wd [2];
    logic        cs [2];
    logic        we [2];
    logic        clken [2];
    logic [31:0] mem_rd [2];

    logic [31:0] ram [2][1024];
    logic [31:0] exp_mem [2][1024];

    int          checks = 0;
    int          errors = 0;

    int          mlast [2] = '{1, 1};
    int          mcnt [2]  = '{0, 0};
    bit          pvld [2]  = '{0, 0};
    int          pown [2]  = '{0, 0};
    logic [31:0] pdata [2];

    onchip_memory_arbiter #(.ARB_MODE(0), .STARVE_LIMIT(LIMIT)) dut_rr (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
        .m0_waitrequest(wr0[0]), .m0_readdata(rd0[0]), .m0_readdatavalid(rdv0[0]),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
        .m1_waitrequest(wr1[0]), .m1_readdata(rd1[0]), .m1_readdatavalid(rdv1[0]),
        .mem_address(mem_addr[0]), .mem_byteenable(mem_be[0]), .mem_writedata(mem_wd[0]),
        .mem_chipselect(cs[0]), .mem_write(we[0]), .mem_clken(clken[0]),
        .mem_readdata(mem_rd[0])
    );

    onchip_memory_arbiter #(.ARB_MODE(1), .STARVE_LIMIT(LIMIT)) dut_fp (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
        .m0_waitrequest(wr0[1]), .m0_readdata(rd0[1]), .m0_readdatavalid(rdv0[1]),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
        .m1_waitrequest(wr1[1]), .m1_readdata(rd1[1]), .m1_readdatavalid(rdv1[1]),
        .mem_address(mem_addr[1]), .mem_byteenable(mem_be[1]), .mem_writedata(mem_wd[1]),
        .mem_chipselect(cs[1]), .mem_write(we[1]), .mem_clken(clken[1]),
        .mem_readdata(mem_rd[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM per instance: byte-lane writes, registered read data.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (cs[k] && clken[k]) begin
                if (we[k]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (mem_be[k][b]) ram[k][mem_addr[k]][8*b +: 8] = mem_wd[k][8*b +: 8];
                    end
                end else begin
                    mem_rd[k] <= ram[k][mem_addr[k]];
                end
            end
        end
    end

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got %h want %h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Which requester the rules award this cycle: -1 none, 0 or 1.
    function automatic int pick(input int k);
        bit a0, a1;
        a0 = m0_read | m0_write;
        a1 = m1_read | m1_write;
        if (!reset_n || (!a0 && !a1)) return -1;
        if (a0 && !a1) return 0;
        if (a1 && !a0) return 1;
        if (k == 0) return 1 - mlast[k];
        return (mcnt[k] == LIMIT) ? 1 : 0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                mlast[k] = 1;
                mcnt[k]  = 0;
                pvld[k]  = 0;
                pown[k]  = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                int         g;
                bit         gw;
                logic [9:0] ga;
                logic [3:0] gb;
                logic [31:0] gd;
                bit         cont;
                g    = pick(k);
                cont = (m0_read | m0_write) && (m1_read | m1_write);
                pvld[k] = 0;
                if (g >= 0) begin
                    gw = (g == 1) ? m1_write : m0_write;
                    ga = (g == 1) ? m1_address : m0_address;
                    gb = (g == 1) ? m1_byteenable : m0_byteenable;
                    gd = (g == 1) ? m1_writedata : m0_writedata;
                    if (gw) begin
                        for (int b = 0; b < 4; b++) begin
                            if (gb[b]) exp_mem[k][ga][8*b +: 8] = gd[8*b +: 8];
                        end
                    end else begin
                        pvld[k]  = 1;
                        pown[k]  = g;
                        pdata[k] = exp_mem[k][ga];
                    end
                    mlast[k] = g;
                end
                mcnt[k] = (cont && g == 0) ? mcnt[k] + 1 : 0;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int g;
            bit a0, a1, gw;
            g  = pick(k);
            a0 = m0_read | m0_write;
            a1 = m1_read | m1_write;
            gw = (g == 1) ? m1_write : m0_write;
            chk("m_wait0", k, 32'(wr0[k]), 32'(a0 && g != 0));
            chk("m_wait1", k, 32'(wr1[k]), 32'(a1 && g != 1));
            chk("m_cs", k, 32'(cs[k]), 32'(g >= 0));
            chk("m_we", k, 32'(we[k]), 32'(g >= 0 && gw));
            chk("m_clken", k, 32'(clken[k]), 32'd1);
            if (g >= 0) begin
                chk("m_addr", k, 32'(mem_addr[k]), 32'((g == 1) ? m1_address : m0_address));
                if (gw) begin
                    chk("m_be", k, 32'(mem_be[k]), 32'((g == 1) ? m1_byteenable : m0_byteenable));
                    chk("m_wd", k, mem_wd[k], (g == 1) ? m1_writedata : m0_writedata);
                end
            end
            chk("m_rdv0", k, 32'(rdv0[k]), 32'(pvld[k] && pown[k] == 0));
            chk("m_rdv1", k, 32'(rdv1[k]), 32'(pvld[k] && pown[k] == 1));
            if (pvld[k]) chk("m_rdata", k, (pown[k] == 1) ? rd1[k] : rd0[k], pdata[k]);
        end
    end

    task automatic idle();
        m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
        m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 1024; i++) begin
                ram[k][i]     = 32'hA5A5_0000 | 32'(i);
                exp_mem[k][i] = 32'hA5A5_0000 | 32'(i);
            end
        end
        reset_n = 1'b0;
        idle();

        step();
        m0_read = 1; m0_address = 10'h001;
        m1_write = 1; m1_address = 10'h005; m1_byteenable = 4'hF; m1_writedata = 32'h1234_5678;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_wait0", k, 32'(wr0[k]), 32'd1);
            chk("rst_wait1", k, 32'(wr1[k]), 32'd1);
            chk("rst_cs", k, 32'(cs[k]), 32'd0);
            chk("rst_we", k, 32'(we[k]), 32'd0);
        end

        step();
        idle();
        reset_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("idle_wait0", k, 32'(wr0[k]), 32'd0);
            chk("idle_wait1", k, 32'(wr1[k]), 32'd0);
            chk("idle_rdv0", k, 32'(rdv0[k]), 32'd0);
            chk("idle_cs", k, 32'(cs[k]), 32'd0);
        end

        // Both reading continuously.
        step();
        m0_read = 1; m0_address = 10'h010;
        m1_read = 1; m1_address = 10'h020;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rr_wait0", 0, 32'(wr0[0]), 32'(i % 2));
            if (i > 0) begin
                if (i % 2 == 1) begin
                    chk("rr_rdv0", 0, 32'(rdv0[0]), 32'd1);
                    chk("rr_rd0", 0, rd0[0], 32'hA5A5_0010);
                end else begin
                    chk("rr_rdv1", 0, 32'(rdv1[0]), 32'd1);
                    chk("rr_rd1", 0, rd1[0], 32'hA5A5_0020);
                end
            end
            chk("fp_wait1", 1, 32'(wr1[1]), 32'(i % 5 != 4));
            step();
        end
        idle();
        step();

        // Partial write by m1 then read-back by m0 the next cycle.
        m1_write = 1; m1_address = 10'h3FF; m1_writedata = 32'hDEAD_BEEF; m1_byteenable = 4'b0011;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("wr_we", k, 32'(we[k]), 32'd1);
            chk("wr_wait1", k, 32'(wr1[k]), 32'd0);
        end
        step();
        idle();
        m0_read = 1; m0_address = 10'h3FF;
        step();
        idle();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("raw_rdv0", k, 32'(rdv0[k]), 32'd1);
            chk("raw_rd0", k, rd0[k], 32'hA5A5_BEEF);
            chk("raw_rdv1", k, 32'(rdv1[k]), 32'd0);
        end

        // Mixed traffic over a small address window, including read+write together.
        for (int i = 0; i < 200; i++) begin
            step();
            m0_read = 1'($urandom_range(0, 1)); m0_write = 1'($urandom_range(0, 1));
            m1_read = 1'($urandom_range(0, 1)); m1_write = 1'($urandom_range(0, 1));
            m0_address = 10'($urandom_range(0, 7)); m1_address = 10'($urandom_range(0, 7));
            m0_byteenable = 4'($urandom); m1_byteenable = 4'($urandom);
            m0_writedata = $urandom; m1_writedata = $urandom;
        end
        step();
        idle();
        step();
        step();

        // Read in flight when reset pulses: it must vanish, and m0 wins the next contest.
        step();
        m0_read = 1; m0_address = 10'h010;
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk("pre_wait0", k, 32'(wr0[k]), 32'd0);
        @(posedge clk);
        #2;
        idle();
        reset_n = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("prst_rdv0", k, 32'(rdv0[k]), 32'd0);
            chk("prst_rdv1", k, 32'(rdv1[k]), 32'd0);
        end
        #2;
        reset_n = 1'b1;
        step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk("post_rdv0", k, 32'(rdv0[k]), 32'd0);
        step();
        m0_read = 1; m0_address = 10'h011;
        m1_read = 1; m1_address = 10'h021;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("post_wait0", k, 32'(wr0[k]), 32'd0);
            chk("post_wait1", k, 32'(wr1[k]), 32'd1);
        end
        step();
        idle();
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
